// File: rtl/decode_queue_if.sv
// Decoded-instruction record types and the fetch/issue-facing bundle of the
// decode queue.

package decode_queue_pkg;

  typedef enum logic [3:0] {
    OP_INVALID,
    OP_ADDU,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_LUI,
    OP_BEQ,
    OP_BNE,
    OP_J,
    OP_JAL,
    OP_JR
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        is_controlflow;
  } decoded_instr_t;

endpackage

interface decode_queue_if #(
  parameter int unsigned FETCH_NUM = 2,
  parameter int unsigned ISSUE_NUM = 2
);
  localparam int unsigned ISS_W = $clog2(ISSUE_NUM + 1);

  logic                                         flush;
  logic [FETCH_NUM-1:0]                         in_valid;
  logic [FETCH_NUM-1:0][31:0]                   in_instr;
  logic [FETCH_NUM-1:0][31:0]                   in_pc;
  logic                                         in_ready;
  logic [ISSUE_NUM-1:0]                         out_valid;
  decode_queue_pkg::decoded_instr_t [ISSUE_NUM-1:0] out_decoded;
  logic [ISSUE_NUM-1:0][31:0]                   out_pc;
  logic [ISSUE_NUM-1:0]                         out_delayslot;
  logic [ISS_W-1:0]                             issue_num;

  modport master (
    output flush, in_valid, in_instr, in_pc, issue_num,
    input  in_ready, out_valid, out_decoded, out_pc, out_delayslot
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, issue_num,
    output in_ready, out_valid, out_decoded, out_pc, out_delayslot
  );

endinterface

// File: rtl/decode_queue.sv
// Multi-lane decode buffer: decodes fetched MIPS32 words on entry into a
// circular queue and holds back a branch until its delay slot can issue with it.

module decoder
  import decode_queue_pkg::*;
(
  input  logic [31:0]    instr_i,
  output decoded_instr_t dec_o
);
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = instr_i[31:26];
  assign rs       = instr_i[25:21];
  assign rt       = instr_i[20:16];
  assign rd       = instr_i[15:11];
  assign shamt    = instr_i[10:6];
  assign funct    = instr_i[5:0];
  assign imm16    = instr_i[15:0];
  assign target   = instr_i[25:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};

  always_comb begin
    dec_o = '0;
    case (opcode)
      6'h00: begin
        dec_o.rs1 = rs;
        dec_o.rs2 = rt;
        dec_o.rd  = rd;
        case (funct)
          6'h00: begin
            dec_o.op      = OP_SLL;
            dec_o.rs1     = rt;
            dec_o.rs2     = '0;
            dec_o.imm     = {27'h0, shamt};
            dec_o.use_imm = 1'b1;
          end
          6'h08: begin
            dec_o.op             = OP_JR;
            dec_o.rs2            = '0;
            dec_o.rd             = '0;
            dec_o.is_controlflow = 1'b1;
          end
          6'h21:   dec_o.op = OP_ADDU;
          6'h23:   dec_o.op = OP_SUBU;
          6'h24:   dec_o.op = OP_AND;
          6'h25:   dec_o.op = OP_OR;
          6'h26:   dec_o.op = OP_XOR;
          default: dec_o.op = OP_INVALID;
        endcase
      end
      6'h02, 6'h03: begin
        dec_o.op             = (opcode == 6'h03) ? OP_JAL : OP_J;
        dec_o.rd             = (opcode == 6'h03) ? 5'd31 : 5'd0;
        dec_o.imm            = {6'h00, target};
        dec_o.use_imm        = 1'b1;
        dec_o.is_controlflow = 1'b1;
      end
      6'h04, 6'h05: begin
        dec_o.op             = (opcode == 6'h04) ? OP_BEQ : OP_BNE;
        dec_o.rs1            = rs;
        dec_o.rs2            = rt;
        dec_o.imm            = imm_sext;
        dec_o.is_controlflow = 1'b1;
      end
      // I-type ALU ops write rt; the immediate replaces rs2.
      6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec_o.rs1     = (opcode == 6'h0F) ? 5'd0 : rs;
        dec_o.rd      = rt;
        dec_o.use_imm = 1'b1;
        case (opcode)
          6'h09:   begin dec_o.op = OP_ADDU; dec_o.imm = imm_sext; end
          6'h0C:   begin dec_o.op = OP_AND;  dec_o.imm = imm_zext; end
          6'h0D:   begin dec_o.op = OP_OR;   dec_o.imm = imm_zext; end
          6'h0E:   begin dec_o.op = OP_XOR;  dec_o.imm = imm_zext; end
          default: begin dec_o.op = OP_LUI;  dec_o.imm = {imm16, 16'h0000}; end
        endcase
      end
      default: dec_o.op = OP_INVALID;
    endcase
  end

endmodule

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned FETCH_NUM = 2,
  parameter int unsigned ISSUE_NUM = 2,
  parameter int unsigned DEPTH     = 8
) (
  input logic           clk,
  input logic           rst,
  decode_queue_if.slave dq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  decoded_instr_t ent_q [DEPTH];
  logic [31:0]    pc_q  [DEPTH];
  logic           ds_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_cf_q, last_cf_d;

  decoded_instr_t [FETCH_NUM-1:0] dec;
  logic [FETCH_NUM-1:0]           lane_ds;
  logic [CNT_W-1:0]               enq_n;
  logic                           lane_last_cf;
  logic                           prev_cf;
  logic                           in_ready_c;
  logic                           enq;

  logic [ISSUE_NUM-1:0]                 out_valid_c;
  decoded_instr_t [ISSUE_NUM-1:0]       out_decoded_c;
  logic [ISSUE_NUM-1:0][31:0]           out_pc_c;
  logic [ISSUE_NUM-1:0]                 out_ds_c;
  logic [PTR_W-1:0]                     rd_idx;
  logic                                 present;
  logic                                 blocked;

  for (genvar j = 0; j < FETCH_NUM; j++) begin : g_dec
    decoder u_dec (
      .instr_i (dq.in_instr[j]),
      .dec_o   (dec[j])
    );
  end

  assign in_ready_c = (count_q <= CNT_W'(DEPTH - FETCH_NUM));
  assign enq        = in_ready_c && (dq.in_valid != '0) && !dq.flush;

  // Delay-slot marking chains through the lanes, seeded by the previous group.
  always_comb begin
    enq_n        = '0;
    lane_last_cf = last_cf_q;
    prev_cf      = last_cf_q;
    lane_ds      = '0;
    for (int j = 0; j < FETCH_NUM; j++) begin
      lane_ds[j] = prev_cf;
      prev_cf    = dec[j].is_controlflow;
      if (dq.in_valid[j]) begin
        enq_n        = enq_n + CNT_W'(1);
        lane_last_cf = dec[j].is_controlflow;
      end
    end
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    last_cf_d = last_cf_q;
    if (dq.flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      last_cf_d = 1'b0;
    end else begin
      head_d  = head_q + PTR_W'(dq.issue_num);
      count_d = count_q - CNT_W'(dq.issue_num);
      if (enq) begin
        tail_d    = tail_q + PTR_W'(enq_n);
        count_d   = count_d + enq_n;
        last_cf_d = lane_last_cf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      last_cf_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      last_cf_q <= last_cf_d;
    end
  end

  // Entry storage carries no reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int j = 0; j < FETCH_NUM; j++) begin
        if (dq.in_valid[j]) begin
          ent_q[tail_q + PTR_W'(j)] <= dec[j];
          pc_q[tail_q + PTR_W'(j)]  <= dq.in_pc[j];
          ds_q[tail_q + PTR_W'(j)]  <= lane_ds[j];
        end
      end
    end
  end

  // A branch that is the last shown lane, or the last queued entry, waits
  // until its delay slot can go out in the same group.
  always_comb begin
    out_valid_c   = '0;
    out_decoded_c = '0;
    out_pc_c      = '0;
    out_ds_c      = '0;
    rd_idx        = '0;
    present       = 1'b0;
    blocked       = 1'b0;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      rd_idx  = head_q + PTR_W'(i);
      present = (CNT_W'(i) < count_q);
      if ((ISSUE_NUM > 1) && present && ent_q[rd_idx].is_controlflow && !ds_q[rd_idx] &&
          ((i == ISSUE_NUM - 1) || (CNT_W'(i + 1) >= count_q))) begin
        blocked = 1'b1;
      end
      out_valid_c[i]   = present && !blocked;
      out_decoded_c[i] = ent_q[rd_idx];
      out_pc_c[i]      = pc_q[rd_idx];
      out_ds_c[i]      = present && ds_q[rd_idx];
    end
  end

  assign dq.in_ready      = in_ready_c;
  assign dq.out_valid     = out_valid_c;
  assign dq.out_decoded   = out_decoded_c;
  assign dq.out_pc        = out_pc_c;
  assign dq.out_delayslot = out_ds_c;

endmodule
